// File: rtl/fe_tx_burst_desc_queue_pkg.sv
// Shared defaults for the TX burst descriptor queue: field widths, depth and late threshold.
package fe_tx_burst_desc_queue_pkg;

  localparam int unsigned TS_BITS_DEF        = 30;
  localparam int unsigned LOW_ADDDR_BITS_DEF = 13;
  localparam int unsigned DESC_ADDR_BITS_DEF = 4;
  localparam int          LATE_THRESH_DEF    = 0;

endpackage

// File: rtl/fe_tx_desc_ram.sv
// Descriptor storage: DEPTH x DW distributed RAM, synchronous write, asynchronous read.
module fe_tx_desc_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 43
) (
  input  logic          mclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_c
);

  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge mclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/fe_tx_burst_desc_queue.sv
// Burst-descriptor queue feeding the TX burst front end: lookahead head, deferred slot release,
// occupancy status and late-start statistics.
module fe_tx_burst_desc_queue
  import fe_tx_burst_desc_queue_pkg::*;
#(
  parameter int unsigned TS_BITS        = TS_BITS_DEF,
  parameter int unsigned LOW_ADDDR_BITS = LOW_ADDDR_BITS_DEF,
  parameter int unsigned DESC_ADDR_BITS = DESC_ADDR_BITS_DEF,
  parameter int          LATE_THRESH    = LATE_THRESH_DEF
) (
  input  logic                      mclk,
  input  logic                      arst,
  input  logic                      flush,
  input  logic                      desc_wr_valid,
  output logic                      desc_wr_ready,
  input  logic [TS_BITS-1:0]        desc_wr_start,
  input  logic [LOW_ADDDR_BITS-1:0] desc_wr_samples,
  output logic                      ts_rd_valid,
  output logic [TS_BITS-1:0]        ts_rd_start,
  output logic [LOW_ADDDR_BITS-1:0] ts_rd_samples,
  input  logic                      ts_rd_addr_inc,
  input  logic                      ts_rd_addr_processed_inc,
  input  logic [TS_BITS-1:0]        ts_rd_addr_late_samples,
  output logic [DESC_ADDR_BITS:0]   desc_free,
  output logic [DESC_ADDR_BITS:0]   desc_inflight,
  output logic [15:0]               bursts_done,
  output logic [15:0]               late_cnt,
  output logic [TS_BITS-1:0]        late_max,
  output logic                      late_event,
  input  logic                      late_clr,
  output logic                      err_underrun
);

  localparam int unsigned DEPTH = 2**DESC_ADDR_BITS;
  localparam int unsigned PW    = DESC_ADDR_BITS + 1;
  localparam int unsigned DW    = TS_BITS + LOW_ADDDR_BITS;
  localparam logic [PW-1:0]             DEPTH_P   = PW'(DEPTH);
  localparam logic signed [TS_BITS-1:0] THRESH_TS = TS_BITS'(LATE_THRESH);

  logic [PW-1:0] wr_ptr, rd_ptr, proc_ptr;
  logic [PW-1:0] wr_nxt, rd_nxt, proc_nxt;
  logic          wr_acc_c, inc_acc_c, proc_acc_c, late_hit_c, err_c;
  logic [DW-1:0] wr_data_c, rd_data_c, head_c;

  // Accept decisions use only registered state, so same-cycle requests stay independent.
  always_comb begin
    wr_acc_c   = desc_wr_valid && desc_wr_ready && !flush;
    inc_acc_c  = ts_rd_addr_inc && ts_rd_valid && !flush;
    proc_acc_c = ts_rd_addr_processed_inc && (proc_ptr != rd_ptr) && !flush;
    err_c      = !flush && ((ts_rd_addr_inc && !ts_rd_valid) ||
                            (ts_rd_addr_processed_inc && (proc_ptr == rd_ptr)));
    late_hit_c = inc_acc_c && ($signed(ts_rd_addr_late_samples) > THRESH_TS);
    wr_nxt     = wr_ptr;
    rd_nxt     = rd_ptr;
    proc_nxt   = proc_ptr;
    if (flush) begin
      wr_nxt   = '0;
      rd_nxt   = '0;
      proc_nxt = '0;
    end else begin
      if (wr_acc_c)   wr_nxt   = wr_ptr + PW'(1);
      if (inc_acc_c)  rd_nxt   = rd_ptr + PW'(1);
      if (proc_acc_c) proc_nxt = proc_ptr + PW'(1);
    end
    wr_data_c = {desc_wr_start, desc_wr_samples};
    // The slot being written this cycle is not yet in the RAM; forward it if it becomes the head.
    head_c    = (wr_acc_c && (wr_ptr == rd_nxt)) ? wr_data_c : rd_data_c;
  end

  fe_tx_desc_ram #(
    .AW (DESC_ADDR_BITS),
    .DW (DW)
  ) u_ram (
    .mclk    (mclk),
    .we      (wr_acc_c),
    .waddr   (wr_ptr[DESC_ADDR_BITS-1:0]),
    .wdata   (wr_data_c),
    .raddr   (rd_nxt[DESC_ADDR_BITS-1:0]),
    .rdata_c (rd_data_c)
  );

  // Status outputs are registered from next-state pointers so they line up with the head.
  always_ff @(posedge mclk or posedge arst) begin
    if (arst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      proc_ptr      <= '0;
      desc_wr_ready <= 1'b1;
      ts_rd_valid   <= 1'b0;
      ts_rd_start   <= '0;
      ts_rd_samples <= '0;
      desc_free     <= DEPTH_P;
      desc_inflight <= '0;
      bursts_done   <= '0;
      late_cnt      <= '0;
      late_max      <= '0;
      late_event    <= 1'b0;
      err_underrun  <= 1'b0;
    end else begin
      wr_ptr                       <= wr_nxt;
      rd_ptr                       <= rd_nxt;
      proc_ptr                     <= proc_nxt;
      desc_wr_ready                <= (wr_nxt - proc_nxt) != DEPTH_P;
      ts_rd_valid                  <= rd_nxt != wr_nxt;
      {ts_rd_start, ts_rd_samples} <= head_c;
      desc_inflight                <= rd_nxt - proc_nxt;
      desc_free                    <= DEPTH_P - (wr_nxt - proc_nxt);
      if (proc_acc_c) bursts_done <= bursts_done + 16'd1;
      late_event <= late_hit_c;
      if (late_clr) begin
        late_cnt <= '0;
        late_max <= '0;
      end else if (late_hit_c) begin
        if (late_cnt != 16'hFFFF) late_cnt <= late_cnt + 16'd1;
        if ($signed(ts_rd_addr_late_samples) > $signed(late_max))
          late_max <= ts_rd_addr_late_samples;
      end
      if (flush)      err_underrun <= 1'b0;
      else if (err_c) err_underrun <= 1'b1;
    end
  end

endmodule
